// File: rtl/layer_batch_sequencer_if.sv
// layer_batch_sequencer_if: sequencer <-> scheduler handshake bundle
interface layer_batch_sequencer_if #(
  parameter int LAYER_W = 2,
  parameter int BATCH_W = 4
);
  logic               final_start_signal;
  logic               batch_complete_signal;
  logic [BATCH_W-1:0] current_batch_id;
  logic [LAYER_W-1:0] current_layer_id;
  logic               layer_transition;
  logic               clear_output_bram;
  logic               all_batches_complete;
  modport master (
    output final_start_signal, current_batch_id, current_layer_id,
           layer_transition, clear_output_bram, all_batches_complete,
    input  batch_complete_signal
  );
  modport slave (
    input  final_start_signal, current_batch_id, current_layer_id,
           layer_transition, clear_output_bram, all_batches_complete,
    output batch_complete_signal
  );
endinterface

// File: rtl/layer_batch_sequencer.sv
// layer_batch_sequencer: per-layer batch sequencing with BRAM clear before each layer start
module layer_batch_sequencer #(
  parameter int NUM_LAYERS = 4,
  parameter int LAYER_W = 2,
  parameter int BATCH_W = 4,
  parameter logic [NUM_LAYERS*BATCH_W-1:0] LAYER_BATCHES = {4'd1, 4'd2, 4'd4, 4'd8},
  parameter bit USE_EXT_LAYER = 1'b0,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               weight_write_done,
  input  logic               ifmap_write_done,
  input  logic               ext_scheduler_start,
  input  logic [LAYER_W-1:0] ext_layer_id,
  input  logic               abort,
  layer_batch_sequencer_if.master sched,
  output logic               wait_weight,
  output logic               busy,
  output logic               protocol_error
);
  localparam int CW = $clog2(CLEAR_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, CLEARING, RUNNING, WAIT_RELOAD, LAYER_DONE} state_t;
  state_t             state, state_n;
  logic               w_prev, i_prev, w_loaded, i_loaded, w_loaded_n, i_loaded_n;
  logic               start_pulse, start_n, trans, trans_n, clear, clear_n, err_n;
  logic [CW-1:0]      clr_cnt, clr_cnt_n;
  logic [BATCH_W-1:0] batch, batch_n, cnt_raw, cnt;
  logic [LAYER_W-1:0] layer, layer_n, ptr, ptr_n, sel_layer;
  logic               w_pe, i_pe, ready, bad_ext, last;
  assign w_pe      = weight_write_done & ~w_prev;
  assign i_pe      = ifmap_write_done & ~i_prev;
  assign ready     = (w_loaded | w_pe) & (i_loaded | i_pe);
  assign bad_ext   = USE_EXT_LAYER && ({1'b0, ext_layer_id} >= (LAYER_W+1)'(NUM_LAYERS));
  assign sel_layer = bad_ext ? '0 : (USE_EXT_LAYER ? ext_layer_id : ptr);
  assign cnt_raw   = LAYER_BATCHES[int'(layer)*BATCH_W +: BATCH_W];
  assign cnt       = (cnt_raw == '0) ? BATCH_W'(1) : cnt_raw;
  assign last      = batch == cnt - BATCH_W'(1);
  always_comb begin
    state_n    = state;
    w_loaded_n = w_loaded | w_pe;
    i_loaded_n = i_loaded | i_pe;
    batch_n    = batch;
    layer_n    = layer;
    ptr_n      = ptr;
    clr_cnt_n  = clr_cnt;
    clear_n    = clear;
    trans_n    = 1'b0;
    start_n    = 1'b0;
    err_n      = protocol_error | (sched.batch_complete_signal & (state != RUNNING));
    if (abort) begin
      state_n    = IDLE;
      w_loaded_n = 1'b0;
      i_loaded_n = 1'b0;
      batch_n    = '0;
      ptr_n      = '0;
      clr_cnt_n  = '0;
      clear_n    = 1'b0;
      err_n      = 1'b0;
    end else begin
      case (state)
        IDLE, LAYER_DONE: if (ready) begin
          state_n    = CLEARING;
          w_loaded_n = 1'b0;
          i_loaded_n = 1'b0;
          batch_n    = '0;
          layer_n    = sel_layer;
          ptr_n      = (sel_layer == LAYER_W'(NUM_LAYERS - 1)) ? '0 : sel_layer + LAYER_W'(1);
          clr_cnt_n  = '0;
          clear_n    = 1'b1;
          trans_n    = 1'b1;
          err_n      = err_n | bad_ext;
        end
        CLEARING: if (clr_cnt == CW'(CLEAR_CYCLES - 1)) begin
          state_n = RUNNING;
          clear_n = 1'b0;
          start_n = 1'b1;
        end else clr_cnt_n = clr_cnt + CW'(1);
        RUNNING: if (sched.batch_complete_signal) begin
          state_n = last ? LAYER_DONE : WAIT_RELOAD;
          batch_n = last ? batch : batch + BATCH_W'(1);
        end
        WAIT_RELOAD: begin
          // reload edges are consumed here rather than latched for the next layer
          w_loaded_n = w_loaded;
          i_loaded_n = i_loaded;
          err_n      = err_n | i_pe;
          state_n    = w_pe ? RUNNING : state;
          start_n    = w_pe;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      w_prev         <= 1'b0;
      i_prev         <= 1'b0;
      w_loaded       <= 1'b0;
      i_loaded       <= 1'b0;
      batch          <= '0;
      layer          <= '0;
      ptr            <= '0;
      clr_cnt        <= '0;
      clear          <= 1'b0;
      trans          <= 1'b0;
      start_pulse    <= 1'b0;
      protocol_error <= 1'b0;
    end else begin
      state          <= state_n;
      w_prev         <= weight_write_done;
      i_prev         <= ifmap_write_done;
      w_loaded       <= w_loaded_n;
      i_loaded       <= i_loaded_n;
      batch          <= batch_n;
      layer          <= layer_n;
      ptr            <= ptr_n;
      clr_cnt        <= clr_cnt_n;
      clear          <= clear_n;
      trans          <= trans_n;
      start_pulse    <= start_n;
      protocol_error <= err_n;
    end
  end
  assign sched.final_start_signal   = ext_scheduler_start | start_pulse;
  assign sched.current_batch_id     = batch;
  assign sched.current_layer_id     = layer;
  assign sched.layer_transition     = trans;
  assign sched.clear_output_bram    = clear;
  assign sched.all_batches_complete = state == LAYER_DONE;
  assign wait_weight                = state == WAIT_RELOAD;
  assign busy                       = (state == CLEARING) | (state == RUNNING) | (state == WAIT_RELOAD);
endmodule

// File: doc/layer_batch_sequencer.md
Name: layer_batch_sequencer

Overview:
- Parametrised multi-layer batch sequencer for the transpose-convolution accelerator.
- Sits between the AXI ifmap/weight loader wrappers and the main scheduler FSM.
- Per-layer batch counts come from a parameter table. The active layer is auto-sequenced or selected externally.
- Output-BRAM clearing is completed before any start pulse is issued. Protocol violations are flagged.

Parameters:
NUM_LAYERS, 4, number of layers in the table (2..16)
LAYER_W, 2, layer id width; must satisfy 2**LAYER_W >= NUM_LAYERS
BATCH_W, 4, batch id / batch count width
LAYER_BATCHES, {4'd1,4'd2,4'd4,4'd8}, packed NUM_LAYERS*BATCH_W; slice i = batch count of layer i (layer 0 in LSBs); value 0 treated as 1
USE_EXT_LAYER, 0, 1 = take layer from ext_layer_id; 0 = auto-sequence
CLEAR_CYCLES, 2, cycles clear_output_bram is held (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
weight_write_done  in  1  level from weight AXI wrapper; rising edge = weight load complete
ifmap_write_done  in  1  level from ifmap AXI wrapper; rising edge = ifmap load complete
ext_scheduler_start  in  1  manual start, ORed into final_start_signal
ext_layer_id  in  LAYER_W  external layer select, sampled at layer start when USE_EXT_LAYER=1
abort  in  1  synchronous return to IDLE
batch_complete_signal  in  1  one-cycle pulse from scheduler FSM per finished batch
final_start_signal  out  1  start pulse to scheduler FSM
current_batch_id  out  BATCH_W  batch index within the layer
current_layer_id  out  LAYER_W  active layer
layer_transition  out  1  one-cycle pulse on layer start
clear_output_bram  out  1  output BRAM clear strobe
all_batches_complete  out  1  high in LAYER_DONE
wait_weight  out  1  high in WAIT_RELOAD
busy  out  1  state is CLEARING, RUNNING or WAIT_RELOAD
protocol_error  out  1  sticky error flag

Behaviour:
- Reset state: IDLE.
  - All outputs reset to 0.
  - Edge-detect previous registers, load flags, and clear counter reset to 0.
  - Auto-sequence pointer resets to 0.
- Edge detect:
  - w_pe = weight_write_done & ~prev; i_pe likewise.
  - Flags weight_loaded/ifmap_loaded set on the respective pe.
  - ready = (weight_loaded|w_pe) & (ifmap_loaded|i_pe).
- IDLE / LAYER_DONE: if ready in cycle T, then at edge T+1:
  - State becomes CLEARING; both flags clear; current_batch_id=0.
  - layer_transition=1 for one cycle; clear_output_bram=1.
  - current_layer_id = ext_layer_id when USE_EXT_LAYER=1, otherwise the sequence pointer.
  - Sequence pointer = (layer+1) mod NUM_LAYERS.
  - If ext_layer_id >= NUM_LAYERS: layer forced to 0 and protocol_error set.
- CLEARING:
  - clear_output_bram is high for exactly CLEAR_CYCLES cycles (T+1..T+CLEAR_CYCLES).
  - At T+CLEAR_CYCLES+1: state RUNNING, final_start_signal=1 for one cycle.
- RUNNING, on batch_complete_signal:
  - If current_batch_id == count-1: go to LAYER_DONE, batch id unchanged.
  - Otherwise: batch id +1, go to WAIT_RELOAD.
- WAIT_RELOAD:
  - w_pe in cycle T gives state RUNNING and final_start_signal=1 at T+1.
  - i_pe here sets protocol_error; the ifmap is unchanged.
  - Weight posedges outside WAIT_RELOAD, IDLE and LAYER_DONE only set weight_loaded.
- LAYER_DONE: all_batches_complete held high until ready. ready moves straight to CLEARING; there is no intermediate IDLE.
- Other protocol_error sources: batch_complete_signal outside RUNNING; the pulse is otherwise ignored.
- protocol_error is cleared only by reset or abort.
- abort (highest priority, any state), next edge:
  - IDLE; flags, batch id, clear counter, protocol_error and sequence pointer reset to 0.
  - current_layer_id holds its value.
  - Any in-flight clear is truncated.
- Simultaneous w_pe & i_pe counts as ready in the same cycle.
- Simultaneous abort and ready: abort wins.
- final_start_signal = ext_scheduler_start | internal pulse (combinational OR). Manual starts never change state.
- Batch count 1: the first batch_complete_signal goes directly to LAYER_DONE.
- Batch id wraps only via a new layer start, never by arithmetic overflow.

Test Plan:
- Reset, then pulse ifmap at cycle 5 and weight at cycle 8 (defaults):
  - layer 0, layer_transition at 9, clear_output_bram 9-10, start at 11.
  - 8 batch_complete pulses, each followed by a weight reload: batch ids 0..7, then all_batches_complete=1, batch id 7.
- Both edges in the same cycle while in LAYER_DONE after layer 0: layer 1 is selected; 4 batches complete, then LAYER_DONE.
- Auto wrap: complete layers 0,1,2 (layer 2 has 2 batches) and 3 (1 batch: a single complete goes to LAYER_DONE); next load selects layer 0.
- USE_EXT_LAYER=1: ext_layer_id=2 gives layer 2; ext_layer_id=3 with NUM_LAYERS=3 gives layer 0 and protocol_error=1.
- Protocol error: batch_complete_signal in IDLE sets protocol_error with state unchanged; i_pe in WAIT_RELOAD also sets it.
- Abort during CLEARING (second clear cycle): next cycle IDLE, clear low, no start pulse; the next load restarts at layer 0.
